// File: rtl/srl_seq_pkg.sv
// Shared constants and state encoding for the sequential right shifter.
package srl_seq_pkg;

    localparam int SRL_WIDTH = 32;
    localparam int SRL_SHW   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Value of the arith input that selects sign fill.
    localparam logic ARITH_SRA = 1'b1;
    localparam logic ARITH_SRL = 1'b0;

endpackage

// File: rtl/srl_seq_srl_1.sv
// Combinational single-position right shift; the vacated MSB takes the fill bit.
module srl_1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             fill,
    output logic [WIDTH-1:0] out_data
);

    assign out_data = {fill, in_data[WIDTH-1:1]};

endmodule

// File: rtl/srl_seq.sv
// Multi-cycle right shifter (logical or arithmetic), one bit position per clock,
// with a start/busy/done handshake.
module srl_seq
    import srl_seq_pkg::*;
#(
    parameter int WIDTH = SRL_WIDTH,
    parameter int SHW   = SRL_SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sreg_shr;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fill_q, fill_d;

    srl_1 #(.WIDTH(WIDTH)) u_srl_1 (
        .in_data  (sreg_q),
        .fill     (fill_q),
        .out_data (sreg_shr)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sreg_d  = data_in;
                    cnt_d   = shamt;
                    // Sign is frozen at capture so later shifts keep the original MSB.
                    fill_d  = (arith == ARITH_SRA) & data_in[WIDTH-1];
                    state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sreg_d = sreg_shr;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    assign result = sreg_q;
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_srl_seq.sv
// Self-checking bench for srl_seq: directed corner cases plus randomized operations
// compared against a shift-operator reference model.
module tb_srl_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp = '0;

    always #5 clock = ~clock;

    srl_seq dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .arith   (arith),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return sd >>> s;
        return d >> s;
    endfunction

    // Entered at a negedge; returns at the negedge of the done cycle with start low.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a, input bit noise);
        int s_i;
        s_i      = int'(s);
        start    = 1'b1;
        data_in  = d;
        shamt    = s;
        arith    = a;
        last_exp = ref_shift(d, s_i, a);
        @(posedge clock);
        for (int c = 1; c <= s_i + 1; c++) begin
            @(negedge clock);
            check($sformatf("busy d=%h s=%0d c=%0d", d, s_i, c), 32'(busy), 32'(c <= s_i));
            check($sformatf("done d=%h s=%0d c=%0d", d, s_i, c), 32'(done), 32'(c == s_i + 1));
            if (c == s_i + 1)
                check($sformatf("result d=%h s=%0d a=%0d", d, s_i, a), result, last_exp);
            if (noise && c <= s_i && (c == 3 || c == 5)) begin
                start   = 1'b1;
                data_in = $urandom;
                shamt   = 5'($urandom);
                arith   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clock);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " idle result held"}, result, last_exp);
    endtask

    initial begin
        bit seen_done;

        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        arith   = 1'b0;
        repeat (2) @(negedge clock);
        check("reset result", result, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        idle_check("post-reset");

        run_op(32'h8000_0000, 5'd4, 1'b1, 1'b0);
        check("sra 4 literal", result, 32'hF800_0000);
        idle_check("sra4");
        run_op(32'h8000_0000, 5'd4, 1'b0, 1'b0);
        check("srl 4 literal", result, 32'h0800_0000);
        idle_check("srl4");
        run_op(32'h1234_5678, 5'd0, 1'b1, 1'b0);
        check("shamt0 literal", result, 32'h1234_5678);
        idle_check("shamt0");
        run_op(32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0);
        check("sra 31 literal", result, 32'hFFFF_FFFF);
        idle_check("sra31");
        run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0);
        check("srl 31 literal", result, 32'h0000_0001);
        idle_check("srl31");
        run_op(32'h0000_F000, 5'd8, 1'b0, 1'b1);
        check("ignored starts literal", result, 32'h0000_00F0);
        idle_check("noise");

        run_op(32'h0000_0100, 5'd1, 1'b0, 1'b0);
        check("b2b first literal", result, 32'h0000_0080);
        run_op(32'h0000_0100, 5'd2, 1'b0, 1'b0);
        check("b2b second literal", result, 32'h0000_0040);
        idle_check("b2b");

        // Abort mid-shift: asynchronous clear, no stray done pulse afterwards.
        start   = 1'b1;
        data_in = 32'hDEAD_BEEF;
        shamt   = 5'd10;
        arith   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("pre-abort busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort result", result, 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clock);
        reset     = 1'b0;
        last_exp  = '0;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (done || busy) seen_done = 1'b1;
        end
        check("no activity after abort", 32'(seen_done), 32'd0);
        check("result after abort", result, 32'd0);
        run_op(32'hC000_0003, 5'd3, 1'b1, 1'b0);
        idle_check("after abort");

        for (int i = 0; i < 25; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic        a;
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            run_op(d, s, a, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_check("random");
        end
        idle_check("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
